quad_input_filter: RTL and testbench

//   Conditions the raw A/B quadrature lines from the mechanical rotary encoder before they reach the encoder/counter stage.
//   - Synchronises each line into clk with two flip-flops, then debounces it.
//   - Flags illegal quadrature jumps, where both clean channels toggle in the same cycle.
//   - A_clean/B_clean drive the counter stage's A/B inputs directly.

---
 rtl/quad_input_filter_pkg.sv | 17 +
 rtl/quad_input_filter_if.sv | 27 ++
 rtl/quad_input_filter_debounce_channel.sv | 59 +++++
 rtl/quad_input_filter.sv | 72 +++++++
 tb/tb_quad_input_filter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/quad_input_filter_pkg.sv
// Shared constants and helpers for the quadrature input filter.
package quad_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 1000;
  localparam int unsigned ERR_W_DEF         = 8;

  // Ceiling log2 with a floor of 1 bit, used to size the stability counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/quad_input_filter_if.sv
// Encoder-side bus: raw A/B lines in, conditioned lines and error status out.
interface quad_input_filter_if
  import quad_pkg::*;
#(
  parameter int unsigned ERR_W = ERR_W_DEF
);

  logic             A;
  logic             B;
  logic             clear_err;
  logic             A_clean;
  logic             B_clean;
  logic             ready;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output A, B, clear_err,
    input  A_clean, B_clean, ready, err, err_count
  );

  modport slave (
    input  A, B, clear_err,
    output A_clean, B_clean, ready, err, err_count
  );

endinterface

// File: rtl/quad_input_filter_debounce_channel.sv
// One encoder line: two-flop synchroniser, stability counter and clean output flop.
module debounce_channel
  import quad_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = clog2(STABLE_CYCLES_DEF)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic synced_o,
  output logic clean_o,
  output logic flip_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             clean_q;
  logic             clean_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Follow the synced level only after it has differed for STABLE_CYCLES cycles.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    flip_c  = 1'b0;
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = s2_q;
      cnt_d   = '0;
      flip_c  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter and clean level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign synced_o = s2_q;
  assign clean_o  = clean_q;

endmodule

// File: rtl/quad_input_filter.sv
// Debounces the encoder A/B lines and flags simultaneous (illegal) clean toggles.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = clog2(STABLE_CYCLES),
  parameter int unsigned ERR_W         = ERR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  quad_input_filter_if.slave  bus
);

  localparam logic [1:0]       FILL_FULL = 2'd2;
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  logic             a_s2, a_clean, a_flip;
  logic             b_s2, b_clean, b_flip;
  logic [1:0]       fill_q, fill_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .raw_i(bus.A),
    .synced_o(a_s2), .clean_o(a_clean), .flip_c(a_flip)
  );

  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .raw_i(bus.B),
    .synced_o(b_s2), .clean_o(b_clean), .flip_c(b_flip)
  );

  // Fill tracking, arming, illegal-toggle detection and saturating error count.
  always_comb begin
    fill_d    = fill_q;
    ready_d   = ready_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (fill_q != FILL_FULL) fill_d = fill_q + 2'd1;
    if (fill_q == FILL_FULL && a_s2 == a_clean && b_s2 == b_clean) ready_d = 1'b1;
    // Both clean flops change on the coming edge: a skipped quadrature state.
    err_d = ready_q & a_flip & b_flip;
    if (bus.clear_err) begin
      err_cnt_d = '0;
    end else if (err_d && err_cnt_q != ERR_MAX) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      fill_q    <= fill_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.A_clean   = a_clean;
  assign bus.B_clean   = b_clean;
  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench for quad_input_filter with STABLE_CYCLES=4, ERR_W=8.
module tb_quad_input_filter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   exp_cnt;

  quad_input_filter_if #(.ERR_W(8)) bus ();

  quad_input_filter #(.STABLE_CYCLES(4), .CNT_W(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    int         cyc;
    logic       ea;
    logic       eb;
    logic       eerr;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_A_clean"},   32'(bus.A_clean), 32'd0);
    chk({nm, "_B_clean"},   32'(bus.B_clean), 32'd0);
    chk({nm, "_ready"},     32'(bus.ready), 32'd0);
    chk({nm, "_err"},       32'(bus.err), 32'd0);
    chk({nm, "_err_count"}, 32'(bus.err_count), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tbl[0] = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[7] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[8] = '{1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[9] = '{1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 8'd1};

    // Reset with A=B=0, then arming.
    rst_n = 1'b0;
    bus.A = 1'b0;
    bus.B = 1'b0;
    bus.clear_err = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    step();
    chk("ready_c2", 32'(bus.ready), 32'd0);
    step();
    chk("ready_c3", 32'(bus.ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("idle_err", 32'(bus.err), 32'd0);
      chk("idle_A_clean", 32'(bus.A_clean), 32'd0);
    end

    // Table: single-channel latency, return to 0, simultaneous step.
    for (int i = 0; i < 10; i++) begin
      bus.A = tbl[i].a;
      bus.B = tbl[i].b;
      repeat (tbl[i].cyc) step();
      chk($sformatf("v%0d_A_clean", i), 32'(bus.A_clean), 32'(tbl[i].ea));
      chk($sformatf("v%0d_B_clean", i), 32'(bus.B_clean), 32'(tbl[i].eb));
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(tbl[i].eerr));
      chk($sformatf("v%0d_err_count", i), 32'(bus.err_count), 32'(tbl[i].ecnt));
      chk($sformatf("v%0d_ready", i), 32'(bus.ready), 32'd1);
    end

    // Bounce 1,0,1,0 then hold 1: only the final held level counts.
    for (int j = 0; j < 4; j++) begin
      bus.A = (j % 2 == 0) ? 1'b1 : 1'b0;
      step();
      chk("bounce_A_clean", 32'(bus.A_clean), 32'd0);
    end
    bus.A = 1'b1;
    repeat (5) step();
    chk("bounce_hold_k4", 32'(bus.A_clean), 32'd0);
    step();
    chk("bounce_hold_k5", 32'(bus.A_clean), 32'd1);
    chk("bounce_err", 32'(bus.err), 32'd0);

    // Bring B up alone, then force 300 illegal steps to saturate the counter.
    bus.B = 1'b1;
    repeat (6) step();
    chk("b_up_B_clean", 32'(bus.B_clean), 32'd1);
    chk("b_up_err", 32'(bus.err), 32'd0);
    exp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      bus.A = ~bus.A;
      bus.B = ~bus.B;
      repeat (5) step();
      chk("sat_pre_err", 32'(bus.err), 32'd0);
      step();
      chk("sat_err", 32'(bus.err), 32'd1);
      if (exp_cnt < 255) exp_cnt++;
      if (i == 9) chk("cnt_after_10", 32'(bus.err_count), 32'(exp_cnt));
    end
    chk("cnt_saturated", 32'(bus.err_count), 32'd255);

    // Clear coinciding with an error: clear wins, err still pulses.
    bus.A = ~bus.A;
    bus.B = ~bus.B;
    repeat (5) step();
    bus.clear_err = 1'b1;
    step();
    bus.clear_err = 1'b0;
    chk("clr_err_pulse", 32'(bus.err), 32'd1);
    chk("clr_cnt", 32'(bus.err_count), 32'd0);
    step();
    chk("clr_err_after", 32'(bus.err), 32'd0);
    chk("clr_cnt_after", 32'(bus.err_count), 32'd0);

    // One more error, then reset in the middle of a debounce count.
    bus.A = ~bus.A;
    bus.B = ~bus.B;
    repeat (6) step();
    chk("pre_rst_cnt", 32'(bus.err_count), 32'd1);
    chk("pre_rst_A_clean", 32'(bus.A_clean), 32'd1);
    bus.A = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");

    // Release reset with A=B=1: clean rises together without err, ready follows.
    bus.A = 1'b1;
    bus.B = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("pu_err", 32'(bus.err), 32'd0);
      if (i == 5) begin
        chk("pu_A_clean_c5", 32'(bus.A_clean), 32'd0);
        chk("pu_B_clean_c5", 32'(bus.B_clean), 32'd0);
      end
      if (i == 6) begin
        chk("pu_A_clean_c6", 32'(bus.A_clean), 32'd1);
        chk("pu_B_clean_c6", 32'(bus.B_clean), 32'd1);
        chk("pu_ready_c6", 32'(bus.ready), 32'd0);
      end
      if (i == 7) chk("pu_ready_c7", 32'(bus.ready), 32'd1);
    end
    chk("pu_err_count", 32'(bus.err_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
